// File: rtl/receivers_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : receivers_arbiter
// Brief    : Round-robin serialiser of lighthouse words from N_RECV receivers
// Revision : 1.0
// ============================================================================
module receivers_arbiter #(
  parameter int N_RECV = 4,
  parameter int ID_W   = 2
) (
  input  logic                 clk_96MHz,
  input  logic                 reset,
  input  logic [N_RECV-1:0]    data_availible,
  input  logic [N_RECV*17-1:0] decoded_data,
  input  logic [N_RECV*24-1:0] timestamp_last_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_sensor_id,
  output logic [16:0]          out_data,
  output logic [23:0]          out_timestamp,
  output logic [N_RECV-1:0]    overrun,
  input  logic [N_RECV-1:0]    clear_overrun
);

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t              state, state_nx;
  logic [N_RECV-1:0]   prev, pending, pending_nx;
  logic [N_RECV-1:0]   rise, take, ovr_set, granted;
  logic [16:0]         cap_data [N_RECV];
  logic [23:0]         cap_ts   [N_RECV];
  logic [ID_W-1:0]     rr_ptr, grant_id, rr_nx;
  logic [ID_W:0]       idx;
  logic                found, grant_fire;

  assign rise  = data_availible & ~prev;
  assign rr_nx = (grant_id == ID_W'(N_RECV - 1)) ? '0 : grant_id + ID_W'(1);

  // First pending receiver at or after rr_ptr, wrapping modulo N_RECV.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int k = 0; k < N_RECV; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_RECV))
        idx = idx - (ID_W+1)'(N_RECV);
      if (!found && pending[idx[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    grant_fire = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_fire = 1'b1;
          state_nx   = OFFER;
        end
      end
      OFFER: begin
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A word arriving on the receiver being granted refills its freed buffer.
  always_comb begin
    granted    = '0;
    take       = '0;
    ovr_set    = '0;
    pending_nx = pending;
    for (int i = 0; i < N_RECV; i++) begin
      granted[i]    = grant_fire && (grant_id == ID_W'(i));
      take[i]       = rise[i] & (~pending[i] | granted[i]);
      ovr_set[i]    = rise[i] & pending[i] & ~granted[i];
      pending_nx[i] = take[i] | (pending[i] & ~granted[i]);
    end
  end

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prev          <= '0;
      pending       <= '0;
      overrun       <= '0;
      rr_ptr        <= '0;
      out_valid     <= 1'b0;
      out_sensor_id <= '0;
      out_data      <= '0;
      out_timestamp <= '0;
      for (int i = 0; i < N_RECV; i++) begin
        cap_data[i] <= '0;
        cap_ts[i]   <= '0;
      end
    end else begin
      state   <= state_nx;
      prev    <= data_availible;
      pending <= pending_nx;
      overrun <= (overrun & ~clear_overrun) | ovr_set;
      if (grant_fire) begin
        out_valid     <= 1'b1;
        out_sensor_id <= grant_id;
        out_data      <= cap_data[grant_id];
        out_timestamp <= cap_ts[grant_id];
        rr_ptr        <= rr_nx;
      end else if (state == OFFER && out_ready) begin
        out_valid <= 1'b0;
      end
      for (int i = 0; i < N_RECV; i++) begin
        if (take[i]) begin
          cap_data[i] <= decoded_data[17*i +: 17];
          cap_ts[i]   <= timestamp_last_data[24*i +: 24];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_receivers_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_receivers_arbiter
// Brief    : Directed self-checking bench for receivers_arbiter
// Revision : 1.0
// ============================================================================
module tb_receivers_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk_96MHz = 1'b0;
  logic            reset;
  logic [N-1:0]    data_availible;
  logic [N*17-1:0] decoded_data;
  logic [N*24-1:0] timestamp_last_data;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_sensor_id;
  logic [16:0]     out_data;
  logic [23:0]     out_timestamp;
  logic [N-1:0]    overrun;
  logic [N-1:0]    clear_overrun;

  int n_checks = 0;
  int n_errors = 0;

  receivers_arbiter #(.N_RECV(N), .ID_W(IW)) dut (
    .clk_96MHz           (clk_96MHz),
    .reset               (reset),
    .data_availible      (data_availible),
    .decoded_data        (decoded_data),
    .timestamp_last_data (timestamp_last_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_sensor_id       (out_sensor_id),
    .out_data            (out_data),
    .out_timestamp       (out_timestamp),
    .overrun             (overrun),
    .clear_overrun       (clear_overrun)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_96MHz);
    #1;
  endtask

  task automatic load(input int i, input logic [16:0] d, input logic [23:0] t);
    decoded_data[17*i +: 17]        = d;
    timestamp_last_data[24*i +: 24] = t;
  endtask

  // Compact view of the offered word for stability / content checks.
  function automatic logic [63:0] word_view();
    return {21'd0, out_valid, out_sensor_id, out_data, out_timestamp};
  endfunction

  function automatic logic [63:0] exp_word(input logic [IW-1:0] id, input logic [16:0] d,
                                           input logic [23:0] t);
    return {21'd0, 1'b1, id, d, t};
  endfunction

  logic [16:0] wd [N];
  logic [23:0] wt [N];
  int          cnt;

  initial begin
    reset = 1'b1;
    data_availible = '0;
    decoded_data = '0;
    timestamp_last_data = '0;
    out_ready = 1'b1;
    clear_overrun = '0;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_word", {out_sensor_id, out_data, out_timestamp}, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick();

    // Single word on receiver 2
    load(2, 17'h1ABCD, 24'h00F00D);
    data_availible[2] = 1'b1;
    tick();
    check("single_latency", out_valid, 0);
    tick();
    check("single_word", word_view(), exp_word(2'd2, 17'h1ABCD, 24'h00F00D));
    check("single_overrun", overrun, 0);
    tick();
    check("single_done", out_valid, 0);
    tick();
    check("single_no_repeat", out_valid, 0);

    // Simultaneous rise on all receivers, from a fresh rr_ptr
    data_availible = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      wd[i] = 17'h10000 | 17'(i * 17'h111 + 17'h5);
      wt[i] = 24'hA00000 | 24'(i * 24'h1234 + 24'h7);
      load(i, wd[i], wt[i]);
    end
    data_availible = '1;
    tick();
    for (int j = 0; j < N; j++) begin
      tick();
      check($sformatf("rr_word%0d", j), word_view(), exp_word(IW'(j), wd[j], wt[j]));
      tick();
      check($sformatf("rr_gap%0d", j), out_valid, 0);
    end

    // Backpressure on id 0 while receiver 1 overruns behind it
    data_availible = '0;
    out_ready = 1'b0;
    tick();
    load(0, 17'h0BEEF, 24'h123456);
    data_availible[0] = 1'b1;
    tick();
    tick();
    check("bp_grant", word_view(), exp_word(2'd0, 17'h0BEEF, 24'h123456));
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) begin load(1, 17'h0AAAA, 24'hAAAAAA); data_availible[1] = 1'b1; end
      if (c == 3) data_availible[1] = 1'b0;
      if (c == 5) begin load(1, 17'h15555, 24'h555555); data_availible[1] = 1'b1; end
      tick();
      check($sformatf("bp_hold%0d", c), word_view(), exp_word(2'd0, 17'h0BEEF, 24'h123456));
    end
    check("ovr_set", overrun, 4'b0010);
    out_ready = 1'b1;
    tick();
    check("bp_release", out_valid, 0);
    tick();
    check("ovr_first_kept", word_view(), exp_word(2'd1, 17'h0AAAA, 24'hAAAAAA));
    check("ovr_sticky", overrun, 4'b0010);
    clear_overrun[1] = 1'b1;
    tick();
    clear_overrun = '0;
    check("ovr_clear", overrun, 0);
    check("ovr_done", out_valid, 0);
    tick();
    check("ovr_no_extra", out_valid, 0);

    // Held level on receiver 3
    data_availible = '0;
    tick();
    load(3, 17'h13333, 24'h333333);
    data_availible[3] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (out_valid) begin
        cnt++;
        check("held_word", word_view(), exp_word(2'd3, 17'h13333, 24'h333333));
      end
    end
    check("held_count", cnt, 1);

    // Reset while offering with two receivers pending
    data_availible = '0;
    out_ready = 1'b0;
    tick();
    data_availible[2:0] = 3'b111;
    tick();
    tick();
    check("mid_offer_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_drop", out_valid, 0);
    data_availible = '0;
    tick();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("post_reset_silent", cnt, 0);
    check("post_reset_overrun", overrun, 0);
    load(2, 17'h00042, 24'h000042);
    data_availible[2] = 1'b1;
    tick();
    tick();
    check("post_reset_new", word_view(), exp_word(2'd2, 17'h00042, 24'h000042));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/receivers_arbiter.md
Name: receivers_arbiter

Overview:
- Collects decoded lighthouse words from N_RECV single-receiver managers and serialises them onto one output stream.
- Each word is tagged with its sensor index and the 24-bit timestamp of its last data.
- Sits between the receiver manager instances and the downstream packetiser/UART.
- Uses round-robin fairness, a one-entry capture buffer per receiver, and a valid/ready output handshake.

Parameters:
- N_RECV, 4, number of receiver managers arbitrated (2..16).
- ID_W, 2, width of the sensor index; must satisfy 2**ID_W >= N_RECV.

Ports:
- clk_96MHz  input  1  system clock from the PLL.
- reset  input  1  asynchronous active-high reset.
- data_availible  input  N_RECV  per-receiver "word ready" level; bit i belongs to receiver i.
- decoded_data  input  N_RECV*17  receiver i word at bits [17*i+16 : 17*i].
- timestamp_last_data  input  N_RECV*24  receiver i timestamp at bits [24*i+23 : 24*i].
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word this cycle.
- out_sensor_id  output  ID_W  index of the receiver that produced the output word.
- out_data  output  17  decoded word.
- out_timestamp  output  24  timestamp of the word.
- overrun  output  N_RECV  sticky per-receiver dropped-word flags.
- clear_overrun  input  N_RECV  synchronous clear for the overrun bits.

Behaviour:
- Reset (async assert) clears everything to 0:
  - out_valid, out_sensor_id, out_data, out_timestamp, overrun
  - all pending bits and buffers
  - the previous-data_availible register
  - rr_ptr
  - state returns to IDLE.
- Reset mid-transfer discards all buffered and offered words; nothing is replayed.
- Capture (per receiver i, every cycle):
  - The event is a rising edge: data_availible[i]==1 and prev[i]==0.
  - prev[i] is registered each cycle. A level held high captures only once.
  - On an event with pending[i]==0: latch data and timestamp into buf[i] and set pending[i] at that clock edge.
  - On an event with pending[i]==1: keep the old buf[i], drop the new word, and set overrun[i].
  - clear_overrun[i] clears overrun[i]. A set and a clear in the same cycle resolve to set.
- State machine:
  - IDLE: if any pending bit is set, grant g = first pending index searching rr_ptr, rr_ptr+1, ... with modulo-N_RECV wrap. On the grant:
    - load out_data/out_timestamp from buf[g] and set out_sensor_id=g
    - assert out_valid, clear pending[g]
    - set rr_ptr = (g+1) mod N_RECV, go to OFFER.
  - IDLE with no pending bits: stay in IDLE, out_valid=0.
  - OFFER: out_* stay stable while out_valid=1 and out_ready=0. On out_valid and out_ready, drop out_valid next cycle and return to IDLE.
- Latency and throughput:
  - An event sampled at edge k sets pending at edge k; the earliest out_valid is edge k+1.
  - One word per 2 cycles maximum; no back-to-back grants.
- Simultaneous events:
  - A capture on receiver g in the same cycle g is granted: the grant takes the old buf[g]. The new word goes into buf[g] and pending[g] stays 1. No overrun is flagged.
  - Several receivers pending: round-robin order strictly from rr_ptr.
- out_ready while out_valid=0 is ignored.
- Data and timestamp widths are fixed at 17 and 24 bits; no arithmetic is done on them.

Test Plan:
- Single word:
  - Stimulus: reset, then data_availible[2] rises with data 17'h1ABCD, ts 24'h00F00D; out_ready=1.
  - Required: out_valid exactly one cycle later with id=2, data=1ABCD, ts=00F00D; pending clear; overrun=0.
- Simultaneous rise:
  - Stimulus: all 4 bits rise together with distinct words; out_ready=1.
  - Required: outputs in id order 0,1,2,3, one every 2 cycles, rr_ptr ending at 0.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after a grant.
  - Required: out_valid and all out_* bits held unchanged; transfer completes on the first cycle out_ready=1.
- Overrun:
  - Stimulus: receiver 1 rises, falls and rises again while its word is still pending behind a stalled OFFER of id 0.
  - Required: overrun[1]=1 and the first word is preserved. clear_overrun[1] then returns overrun[1] to 0.
- Held level:
  - Stimulus: data_availible[3] held high for 50 cycles.
  - Required: exactly one word emitted for id 3.
- Reset mid-OFFER:
  - Stimulus: assert reset asynchronously while out_valid=1 and two receivers are pending.
  - Required: out_valid drops immediately, and no words are emitted after reset release until new edges arrive.
